// File: rtl/note_hit_judge_pkg.sv
// -----------------------------------------------------------------------------
// note_hit_judge_pkg
//   Shared types and constants for the note hit judge:
//     lane_state_e     per-lane judge state (IDLE / ARMED)
//     PTS_*_DEF        default base points for good / perfect hits
//     MULT_T1..T3      streak thresholds for multiplier steps 2, 3, 4
//     MULT_MAX         highest multiplier
//     mult_from_streak multiplier lookup, 1 + min(3, streak/10)
// -----------------------------------------------------------------------------
package note_hit_judge_pkg;

  typedef enum logic {
    LANE_IDLE  = 1'b0,
    LANE_ARMED = 1'b1
  } lane_state_e;

  localparam int PTS_GOOD_DEF    = 1;
  localparam int PTS_PERFECT_DEF = 2;

  localparam int MULT_T1  = 10;
  localparam int MULT_T2  = 20;
  localparam int MULT_T3  = 30;
  localparam int MULT_MAX = 4;

  localparam int STREAK_W = 8;
  localparam int MULT_W   = 3;

  function automatic logic [MULT_W-1:0] mult_from_streak(input logic [STREAK_W-1:0] s);
    if (int'(s) >= MULT_T3)      return MULT_W'(MULT_MAX);
    else if (int'(s) >= MULT_T2) return MULT_W'(3);
    else if (int'(s) >= MULT_T1) return MULT_W'(2);
    else                         return MULT_W'(1);
  endfunction

endpackage

// File: rtl/note_hit_judge_lane_judge.sv
// -----------------------------------------------------------------------------
// note_hit_judge_lane_judge
//   One lane of the hit judge: key synchronizer, falling-edge press detect and
//   the IDLE/ARMED window FSM. Judgments are combinational for the current
//   cycle; the top module registers them into pulses together with the score.
//   Ports:
//     clock_50  system clock
//     resetn    synchronous active-low reset
//     step      one-cycle scroll-step pulse
//     note      lane bit at the look-ahead tap (meaningful only with step)
//     key_n     raw active-low button, asynchronous
//     run       judging enable; 0 freezes the FSM
//     hit       press judged as a hit this cycle (good or perfect)
//     perfect   hit landed on the centre step of the window
//     miss      window expired without a press
//     wrong     press with no armed note
// -----------------------------------------------------------------------------
module note_hit_judge_lane_judge
  import note_hit_judge_pkg::*;
#(
  parameter int HALF_WIN = 2
) (
  input  logic clock_50,
  input  logic resetn,
  input  logic step,
  input  logic note,
  input  logic key_n,
  input  logic run,
  output logic hit,
  output logic perfect,
  output logic miss,
  output logic wrong
);

  localparam int                CNT_W    = $clog2(2*HALF_WIN+2);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(2*HALF_WIN);
  localparam logic [CNT_W-1:0]  CNT_CTR  = CNT_W'(HALF_WIN);

  logic             key_sync_p0;
  logic             key_sync_p1;
  logic             key_sync_p2;
  logic             press;
  lane_state_e      state;
  lane_state_e      state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // ---- key synchronizer (p0,p1) and edge-detect history (p2) ----
  // Runs regardless of run so that a key held across a run=0 period does not
  // produce a stale edge when run returns.
  always_ff @(posedge clock_50) begin
    if (!resetn) begin
      key_sync_p0 <= 1'b1;
      key_sync_p1 <= 1'b1;
      key_sync_p2 <= 1'b1;
    end else begin
      key_sync_p0 <= key_n;
      key_sync_p1 <= key_sync_p0;
      key_sync_p2 <= key_sync_p1;
    end
  end

  assign press = key_sync_p2 & ~key_sync_p1;

  // ---- lane state register ----
  always_ff @(posedge clock_50) begin
    if (!resetn) begin
      state <= LANE_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (run) begin
      case (state)
        LANE_IDLE: begin
          // A press on the same edge as the arrival consumes the note at once.
          if (step && note && !press) begin
            state_nxt = LANE_ARMED;
            cnt_nxt   = '0;
          end
        end
        LANE_ARMED: begin
          if (press || (step && cnt == CNT_LAST)) begin
            // Window closed by a hit or by expiry; a note arriving on the same
            // step opens a fresh window.
            if (step && note) begin
              state_nxt = LANE_ARMED;
              cnt_nxt   = '0;
            end else begin
              state_nxt = LANE_IDLE;
            end
          end else if (step) begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: state_nxt = LANE_IDLE;
      endcase
    end
  end

  always_comb begin
    hit     = 1'b0;
    perfect = 1'b0;
    miss    = 1'b0;
    wrong   = 1'b0;
    if (run) begin
      case (state)
        LANE_IDLE: begin
          if (press) begin
            if (step && note) begin
              // Arm-then-hit: judged with cnt = 0.
              hit     = 1'b1;
              perfect = (HALF_WIN == 0);
            end else begin
              wrong = 1'b1;
            end
          end
        end
        LANE_ARMED: begin
          // A press on the expiry step still counts as a hit.
          if (press) begin
            hit     = 1'b1;
            perfect = (cnt == CNT_CTR);
          end else if (step && cnt == CNT_LAST) begin
            miss = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/note_hit_judge.sv
// -----------------------------------------------------------------------------
// note_hit_judge
//   Judges notes leaving the shift register against player key presses and
//   keeps score, streak, best streak and multiplier.
//   Ports:
//     clock_50       system clock
//     resetn         synchronous active-low reset
//     step           one-cycle scroll-step pulse
//     note_in        per-lane note bits, sampled with step
//     key_n          raw active-low buttons, asynchronous
//     run            game running; 0 freezes judging
//     hit_pulse      one-cycle pulse per good or perfect hit
//     perfect_pulse  one-cycle pulse per perfect hit
//     miss_pulse     one-cycle pulse per expired window
//     wrong_pulse    one-cycle pulse per press with no armed note
//     score          saturating score
//     streak         consecutive hits, saturating at 255
//     max_streak     best streak since reset
//     multiplier     1..4, follows streak one cycle later
// -----------------------------------------------------------------------------
module note_hit_judge
  import note_hit_judge_pkg::*;
#(
  parameter int LANES       = 3,
  parameter int HALF_WIN    = 2,
  parameter int PTS_GOOD    = PTS_GOOD_DEF,
  parameter int PTS_PERFECT = PTS_PERFECT_DEF,
  parameter int SCORE_W     = 16
) (
  input  logic                clock_50,
  input  logic                resetn,
  input  logic                step,
  input  logic [LANES-1:0]    note_in,
  input  logic [LANES-1:0]    key_n,
  input  logic                run,
  output logic [LANES-1:0]    hit_pulse,
  output logic [LANES-1:0]    perfect_pulse,
  output logic [LANES-1:0]    miss_pulse,
  output logic [LANES-1:0]    wrong_pulse,
  output logic [SCORE_W-1:0]  score,
  output logic [STREAK_W-1:0] streak,
  output logic [STREAK_W-1:0] max_streak,
  output logic [MULT_W-1:0]   multiplier
);

  localparam int PTS_TOP  = (PTS_PERFECT > PTS_GOOD) ? PTS_PERFECT : PTS_GOOD;
  localparam int BASE_W   = $clog2(LANES*PTS_TOP+1);
  localparam int PROD_W   = BASE_W + MULT_W;
  localparam int SUM_W    = ((SCORE_W > PROD_W) ? SCORE_W : PROD_W) + 1;
  localparam int HIT_W    = $clog2(LANES+1);

  logic [LANES-1:0]    hit_p0;
  logic [LANES-1:0]    perfect_p0;
  logic [LANES-1:0]    miss_p0;
  logic [LANES-1:0]    wrong_p0;
  logic [BASE_W-1:0]   base_p0;
  logic [HIT_W-1:0]    n_hit_p0;
  logic [PROD_W-1:0]   prod_p0;
  logic [SCORE_W-1:0]  score_nxt;
  logic [STREAK_W-1:0] streak_nxt;
  logic [STREAK_W-1:0] max_nxt;

  function automatic logic [SCORE_W-1:0] sat_add_score(input logic [SCORE_W-1:0] acc,
                                                       input logic [PROD_W-1:0]  inc);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(acc) + SUM_W'(inc);
    if (sum > SUM_W'({SCORE_W{1'b1}})) return '1;
    return sum[SCORE_W-1:0];
  endfunction

  function automatic logic [STREAK_W-1:0] sat_add_streak(input logic [STREAK_W-1:0] s,
                                                         input logic [HIT_W-1:0]    n);
    logic [STREAK_W:0] sum;
    sum = {1'b0, s} + (STREAK_W+1)'(n);
    if (sum[STREAK_W]) return '1;
    return sum[STREAK_W-1:0];
  endfunction

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    note_hit_judge_lane_judge #(
      .HALF_WIN (HALF_WIN)
    ) u_lane_judge (
      .clock_50 (clock_50),
      .resetn   (resetn),
      .step     (step),
      .note     (note_in[l]),
      .key_n    (key_n[l]),
      .run      (run),
      .hit      (hit_p0[l]),
      .perfect  (perfect_p0[l]),
      .miss     (miss_p0[l]),
      .wrong    (wrong_p0[l])
    );
  end

  // ---- p0: per-cycle judgments -> points and streak update ----
  always_comb begin
    base_p0  = '0;
    n_hit_p0 = '0;
    for (int l = 0; l < LANES; l++) begin
      if (perfect_p0[l])  base_p0 = base_p0 + BASE_W'(PTS_PERFECT);
      else if (hit_p0[l]) base_p0 = base_p0 + BASE_W'(PTS_GOOD);
      n_hit_p0 = n_hit_p0 + HIT_W'(hit_p0[l]);
    end
  end

  // Multiplier is the registered value, i.e. the one from before this update.
  assign prod_p0    = PROD_W'(base_p0) * PROD_W'(multiplier);
  assign score_nxt  = sat_add_score(score, prod_p0);
  assign streak_nxt = ((|miss_p0) || (|wrong_p0)) ? '0 : sat_add_streak(streak, n_hit_p0);
  assign max_nxt    = (streak_nxt > max_streak) ? streak_nxt : max_streak;

  // ---- p1: registered pulses and accumulators ----
  always_ff @(posedge clock_50) begin
    if (!resetn) begin
      hit_pulse     <= '0;
      perfect_pulse <= '0;
      miss_pulse    <= '0;
      wrong_pulse   <= '0;
      score         <= '0;
      streak        <= '0;
      max_streak    <= '0;
      multiplier    <= MULT_W'(1);
    end else begin
      hit_pulse     <= hit_p0;
      perfect_pulse <= perfect_p0;
      miss_pulse    <= miss_p0;
      wrong_pulse   <= wrong_p0;
      score         <= score_nxt;
      streak        <= streak_nxt;
      max_streak    <= max_nxt;
      multiplier    <= mult_from_streak(streak);
    end
  end

endmodule

// File: tb/tb_note_hit_judge.sv
// -----------------------------------------------------------------------------
// tb_note_hit_judge
//   Directed vectors for note_hit_judge with hand-computed expectations.
//   Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_note_hit_judge;

  logic        clock_50 = 1'b0;
  logic        resetn   = 1'b0;
  logic        step     = 1'b0;
  logic        run      = 1'b1;
  logic [2:0]  note_in  = 3'b000;
  logic [2:0]  key_n    = 3'b111;
  logic [2:0]  hit_pulse;
  logic [2:0]  perfect_pulse;
  logic [2:0]  miss_pulse;
  logic [2:0]  wrong_pulse;
  logic [15:0] score;
  logic [7:0]  streak;
  logic [7:0]  max_streak;
  logic [2:0]  multiplier;

  int n_checks = 0;
  int n_errors = 0;

  note_hit_judge #(
    .LANES       (3),
    .HALF_WIN    (2),
    .PTS_GOOD    (1),
    .PTS_PERFECT (2),
    .SCORE_W     (16)
  ) dut (
    .clock_50      (clock_50),
    .resetn        (resetn),
    .step          (step),
    .note_in       (note_in),
    .key_n         (key_n),
    .run           (run),
    .hit_pulse     (hit_pulse),
    .perfect_pulse (perfect_pulse),
    .miss_pulse    (miss_pulse),
    .wrong_pulse   (wrong_pulse),
    .score         (score),
    .streak        (streak),
    .max_streak    (max_streak),
    .multiplier    (multiplier)
  );

  always #5 clock_50 = ~clock_50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_pulses(input string tag, input int h, input int p, input int m, input int w);
    check({tag, "_hit"},     32'(hit_pulse),     h);
    check({tag, "_perfect"}, 32'(perfect_pulse), p);
    check({tag, "_miss"},    32'(miss_pulse),    m);
    check({tag, "_wrong"},   32'(wrong_pulse),   w);
  endtask

  task automatic check_stats(input string tag, input int sc, input int st, input int mx, input int mu);
    check({tag, "_score"},  32'(score),      sc);
    check({tag, "_streak"}, 32'(streak),     st);
    check({tag, "_max"},    32'(max_streak), mx);
    check({tag, "_mult"},   32'(multiplier), mu);
  endtask

  task automatic cyc();
    @(negedge clock_50);
  endtask

  task automatic do_step(input logic [2:0] notes);
    step    = 1'b1;
    note_in = notes;
    cyc();
    step    = 1'b0;
    note_in = 3'b000;
  endtask

  // Key falls now; the press is judged on the third rising edge, where the
  // optional step/notes are also presented. Returns with pulses visible.
  task automatic press(input logic [2:0] mask, input logic with_step, input logic [2:0] notes);
    key_n = ~mask;
    cyc();
    cyc();
    step    = with_step;
    note_in = notes;
    cyc();
    step    = 1'b0;
    note_in = 3'b000;
  endtask

  task automatic release_keys();
    key_n = 3'b111;
    repeat (3) cyc();
  endtask

  task automatic good_hit_lane0();
    do_step(3'b001);
    press(3'b001, 1'b0, 3'b000);
    release_keys();
  endtask

  initial begin
    // Reset with all keys held down.
    key_n = 3'b000;
    cyc();
    cyc();
    check_pulses("rst", 0, 0, 0, 0);
    check_stats("rst", 0, 0, 0, 1);
    key_n  = 3'b111;
    resetn = 1'b1;
    repeat (4) cyc();
    check_pulses("rst_release", 0, 0, 0, 0);

    // Perfect hit on the centre step.
    do_step(3'b001);
    do_step(3'b000);
    do_step(3'b000);
    press(3'b001, 1'b0, 3'b000);
    check_pulses("perfect", 1, 1, 0, 0);
    check_stats("perfect", 2, 1, 1, 1);
    key_n = 3'b111;
    cyc();
    check_pulses("perfect_once", 0, 0, 0, 0);
    cyc();
    cyc();

    // Two good hits at cnt = 0.
    for (int i = 0; i < 2; i++) begin
      do_step(3'b001);
      press(3'b001, 1'b0, 3'b000);
      check_pulses("good", 1, 0, 0, 0);
      release_keys();
    end
    check_stats("good2", 4, 3, 3, 1);

    // Miss on lane 1 after the fifth further step.
    do_step(3'b010);
    repeat (4) do_step(3'b000);
    check_pulses("pre_miss", 0, 0, 0, 0);
    do_step(3'b000);
    check_pulses("miss", 0, 0, 2, 0);
    check_stats("miss", 4, 0, 3, 1);

    // Wrong press on idle lane 2.
    press(3'b100, 1'b0, 3'b000);
    check_pulses("wrong", 0, 0, 0, 4);
    check_stats("wrong", 4, 0, 3, 1);
    release_keys();

    // Reset mid-window: no miss afterwards.
    do_step(3'b010);
    do_step(3'b000);
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    check_stats("rst_mid", 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      do_step(3'b000);
      check_pulses("rst_mid_step", 0, 0, 0, 0);
    end

    // Multiplier: ten good hits, then an eleventh at x2.
    for (int i = 0; i < 9; i++) good_hit_lane0();
    do_step(3'b001);
    press(3'b001, 1'b0, 3'b000);
    check_stats("hit10", 10, 10, 10, 1);
    key_n = 3'b111;
    cyc();
    check_stats("mult_up", 10, 10, 10, 2);
    cyc();
    cyc();
    do_step(3'b001);
    press(3'b001, 1'b0, 3'b000);
    check_pulses("hit11", 1, 0, 0, 0);
    check_stats("hit11", 12, 11, 11, 2);
    release_keys();

    // Press on the expiry step: hit, not miss.
    do_step(3'b010);
    repeat (4) do_step(3'b000);
    press(3'b010, 1'b1, 3'b000);
    check_pulses("expiry_hit", 2, 0, 0, 0);
    check_stats("expiry_hit", 14, 12, 12, 2);
    release_keys();

    // Press together with a new note on an idle lane: good hit, lane ends idle.
    press(3'b100, 1'b1, 3'b100);
    check_pulses("arm_hit", 4, 0, 0, 0);
    check_stats("arm_hit", 16, 13, 13, 2);
    release_keys();
    for (int i = 0; i < 5; i++) begin
      do_step(3'b000);
      check_pulses("arm_hit_idle", 0, 0, 0, 0);
    end

    // Three perfect hits in one cycle at streak 9.
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    for (int i = 0; i < 9; i++) good_hit_lane0();
    check_stats("s9", 9, 9, 9, 1);
    do_step(3'b111);
    do_step(3'b000);
    do_step(3'b000);
    press(3'b111, 1'b0, 3'b000);
    check_pulses("tri", 7, 7, 0, 0);
    check_stats("tri", 15, 12, 12, 1);
    key_n = 3'b111;
    cyc();
    check_stats("tri_mult", 15, 12, 12, 2);
    cyc();
    cyc();

    // run = 0 freezes judging; a key held across run rising gives no edge.
    run = 1'b0;
    do_step(3'b001);
    press(3'b001, 1'b0, 3'b000);
    check_pulses("frozen", 0, 0, 0, 0);
    check_stats("frozen", 15, 12, 12, 2);
    cyc();
    run = 1'b1;
    cyc();
    cyc();
    check_pulses("no_stale", 0, 0, 0, 0);
    check_stats("no_stale", 15, 12, 12, 2);
    release_keys();
    // The frozen step must not have armed lane 0.
    press(3'b001, 1'b0, 3'b000);
    check_pulses("post_run", 0, 0, 0, 1);
    check_stats("post_run", 15, 0, 12, 2);
    release_keys();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/note_hit_judge.md
Name: note_hit_judge

Overview:
- Consumer end of the note shift register. The register emits a per-lane "note is approaching the hit line" bit once per scroll step; this block reads it.
- It pairs each note with the player's button presses and judges each one as perfect, good, miss or wrong press.
- It keeps the score, streak and multiplier that drive the LEDs and, later, the VGA HUD.
- Sits between the rate-divider/shift-register path and the board KEY inputs.

Parameters:
- LANES, 3, number of note lanes/buttons
- HALF_WIN, 2, half-width of hit window in scroll steps (window = 2*HALF_WIN+1 steps)
- PTS_GOOD, 1, base points for a non-centre hit
- PTS_PERFECT, 2, base points for a hit on the centre step
- SCORE_W, 16, score width

Ports:
- clock_50  in  1  system clock
- resetn  in  1  synchronous active-low reset
- step  in  1  one-cycle pulse per scroll step (rate-divider enable)
- note_in  in  LANES  lane bits at the look-ahead tap; sampled only when step=1
- key_n  in  LANES  raw pushbuttons, active-low, asynchronous to clock_50
- run  in  1  game running; 0 freezes judging
- hit_pulse  out  LANES  one-cycle pulse per good or perfect hit
- perfect_pulse  out  LANES  one-cycle pulse, perfect hits only (subset of hit_pulse)
- miss_pulse  out  LANES  one-cycle pulse when a note window expires unhit
- wrong_pulse  out  LANES  one-cycle pulse on a press with no armed note
- score  out  SCORE_W  accumulated score, saturating
- streak  out  8  consecutive hits, saturating at 255
- max_streak  out  8  highest streak since reset
- multiplier  out  3  current multiplier, 1..4

Behaviour:
- Interface (already decided): one clock, clock_50. Reset resetn is synchronous and active-low. On resetn=0 at a clock_50 edge, every output and internal register clears: pulses 0, score 0, streak 0, max_streak 0, multiplier 1, all lanes IDLE, synchronizers 1 (released).
- Input conditioning: key_n goes through a 2-flop synchronizer and a falling-edge detector. A press therefore reaches the judge 3 cycles after key_n falls. A held key produces one press. No debounce.
- Per-lane FSM, states IDLE and ARMED, with a step-count register cnt (width clog2(2*HALF_WIN+2)).
- IDLE, step=1 and note_in[l]=1: go to ARMED, cnt=0.
- ARMED, step=1: cnt+1. If cnt was already 2*HALF_WIN, emit miss and go to IDLE, unless note_in[l]=1, in which case re-arm with cnt=0.
- ARMED, press: hit, go to IDLE. Perfect if cnt==HALF_WIN, otherwise good.
- IDLE, press: wrong.
- Simultaneous press and expiry step: the hit wins, no miss.
- Simultaneous press and new-note step in IDLE: arm first, then the press counts as a hit with cnt=0 (good).
- Simultaneous hit and new note on an ARMED lane: score the hit, re-arm with cnt=0.
- Pulses are registered: they assert the cycle after the judging edge and last exactly one cycle.
- Scoring, per cycle:
  - base = sum over lanes hit this cycle of PTS_PERFECT or PTS_GOOD.
  - score += base*multiplier, using the multiplier from before the update; saturates at all-ones.
  - If any miss or wrong this cycle: streak = 0. Otherwise streak += number of hits, saturating at 255.
  - max_streak = max(max_streak, new streak).
  - multiplier = 1 + min(3, streak/10), computed from the registered streak and updated the cycle after streak changes.
- run=0: presses and steps are ignored, lane states and cnt hold, no pulses, score/streak hold. Synchronizers keep running, so no stale edge appears when run rises.
- Reset mid-window: the lane returns to IDLE and no miss is emitted.

Decomposition:
- Shared package: lane state enum (IDLE, ARMED), PTS_* constants, multiplier thresholds (10/20/30), MULT_MAX=4.
- Sub-module lane_judge: synchronizer, edge detect and per-lane FSM. Instantiated LANES times.
- Scoring/accumulation stays in the top module.

Test Plan:
- Reset: hold resetn=0 for 2 cycles with keys pressed -> all pulses 0, score=0, streak=0, multiplier=1.
- Perfect hit: note_in=001 on a step, then 2 further steps, then lane-0 press -> perfect_pulse=001 and hit_pulse=001 for 1 cycle, score=2, streak=1.
- Miss: note_in=010, no press, 5 further steps -> miss_pulse=010 on the 5th, streak reset from 3 to 0, max_streak stays 3.
- Wrong press: press lane 2 while IDLE -> wrong_pulse=100, score unchanged, streak=0.
- Multiplier: 10 consecutive good hits -> multiplier=2 after the 10th; 11th good hit adds 2, giving score=12.
- Corners: press coinciding with the expiry step gives hit, not miss; 3 lanes hit in the same cycle at streak 9 gives streak=12, with score added at multiplier 1.
